// File: rtl/alu_mc_pkg.sv
// Opcode constants and operand-signedness decode shared by the alu_mc execute unit.
// Base-op codes (ALU_*) and M-extension codes (MUL_*/DIV_*) are both indexed by funct3.
package alu_mc_pkg;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SLL  = 3'b001;
   localparam logic [2:0] ALU_SLT  = 3'b010;
   localparam logic [2:0] ALU_SLTU = 3'b011;
   localparam logic [2:0] ALU_XOR  = 3'b100;
   localparam logic [2:0] ALU_SRL  = 3'b101;
   localparam logic [2:0] ALU_OR   = 3'b110;
   localparam logic [2:0] ALU_AND  = 3'b111;

   localparam logic [2:0] MUL_MUL    = 3'b000;
   localparam logic [2:0] MUL_MULH   = 3'b001;
   localparam logic [2:0] MUL_MULHSU = 3'b010;
   localparam logic [2:0] MUL_MULHU  = 3'b011;
   localparam logic [2:0] DIV_DIV    = 3'b100;
   localparam logic [2:0] DIV_DIVU   = 3'b101;
   localparam logic [2:0] DIV_REM    = 3'b110;
   localparam logic [2:0] DIV_REMU   = 3'b111;

   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   // rs1 is treated as two's complement for these M ops
   function automatic logic op_a_signed(input logic [2:0] f3);
      return (f3 == MUL_MUL) || (f3 == MUL_MULH) || (f3 == MUL_MULHSU) ||
             (f3 == DIV_DIV) || (f3 == DIV_REM);
   endfunction

   function automatic logic op_b_signed(input logic [2:0] f3);
      return (f3 == MUL_MUL) || (f3 == MUL_MULH) ||
             (f3 == DIV_DIV) || (f3 == DIV_REM);
   endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Request/response bundle between operand fetch, the alu_mc execute unit and writeback.
interface alu_mc_if #(parameter int XLEN = 32) ();

   logic            in_valid;
   logic            in_ready;
   logic [6:0]      fun7;
   logic [2:0]      fun3;
   logic [XLEN-1:0] rs1;
   logic [XLEN-1:0] rs2;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] res;
   logic            zero;
   logic            neg;

   modport master (
      output in_valid, fun7, fun3, rs1, rs2, out_ready,
      input  in_ready, out_valid, res, zero, neg
   );

   modport slave (
      input  in_valid, fun7, fun3, rs1, rs2, out_ready,
      output in_ready, out_valid, res, zero, neg
   );

endinterface

// File: rtl/alu_mc_mul_div_iter.sv
// Iterative M-extension unit: shift-add multiply and restoring divide on magnitudes,
// one step per cycle for exactly XLEN cycles, with the sign fix-up applied on the output.
module alu_mc_mul_div_iter
   import alu_mc_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN);

   logic [CW-1:0]     cnt_q;
   logic              active_q;
   logic [2:0]        op_q;
   logic              neg_q;
   logic              neg_r_q;
   logic              b_zero_q;
   logic [XLEN-1:0]   a_q;
   logic [2*XLEN-1:0] acc_q;
   logic [2*XLEN-1:0] mcand_q;
   logic [XLEN-1:0]   mplier_q;
   logic [XLEN-1:0]   quo_q;
   logic [XLEN-1:0]   dvsr_q;
   logic [XLEN-1:0]   rem_q;

   logic              a_neg;
   logic              b_neg;
   logic [XLEN-1:0]   a_mag;
   logic [XLEN-1:0]   b_mag;
   logic [XLEN:0]     rem_shift;
   logic [XLEN:0]     diff;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo_s;
   logic [XLEN-1:0]   rem_s;

   always_comb begin
      a_neg     = op_a_signed(op) & a[XLEN-1];
      b_neg     = op_b_signed(op) & b[XLEN-1];
      a_mag     = a_neg ? -a : a;
      b_mag     = b_neg ? -b : b;
      rem_shift = {rem_q, quo_q[XLEN-1]};
      diff      = rem_shift - {1'b0, dvsr_q};
   end

   // Both datapaths step every active cycle; op_q picks which one is reported.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q    <= '0;
         active_q <= 1'b0;
         op_q     <= '0;
         neg_q    <= 1'b0;
         neg_r_q  <= 1'b0;
         b_zero_q <= 1'b0;
         a_q      <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         quo_q    <= '0;
         dvsr_q   <= '0;
         rem_q    <= '0;
      end else if (start) begin
         cnt_q    <= CW'(XLEN-1);
         active_q <= 1'b1;
         op_q     <= op;
         neg_q    <= a_neg ^ b_neg;
         neg_r_q  <= a_neg;
         b_zero_q <= (b == '0);
         a_q      <= a;
         acc_q    <= '0;
         mcand_q  <= {{XLEN{1'b0}}, a_mag};
         mplier_q <= b_mag;
         quo_q    <= a_mag;
         dvsr_q   <= b_mag;
         rem_q    <= '0;
      end else if (active_q) begin
         if (cnt_q == '0) begin
            active_q <= 1'b0;
         end else begin
            cnt_q <= cnt_q - 1'b1;
         end
         if (mplier_q[0]) begin
            acc_q <= acc_q + mcand_q;
         end
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         if (!diff[XLEN]) begin
            rem_q <= diff[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], 1'b1};
         end else begin
            rem_q <= rem_shift[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], 1'b0};
         end
      end
   end

   assign done = active_q && (cnt_q == '0);

   always_comb begin
      prod   = neg_q ? -acc_q : acc_q;
      quo_s  = neg_q ? -quo_q : quo_q;
      rem_s  = neg_r_q ? -rem_q : rem_q;
      result = '0;
      case (op_q)
         MUL_MUL:    result = prod[XLEN-1:0];
         MUL_MULH,
         MUL_MULHSU,
         MUL_MULHU:  result = prod[2*XLEN-1:XLEN];
         DIV_DIV,
         DIV_DIVU:   result = b_zero_q ? '1 : quo_s;
         DIV_REM,
         DIV_REMU:   result = b_zero_q ? a_q : rem_s;
         default:    result = '0;
      endcase
   end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute unit: single-cycle RV base ops, XLEN-cycle M-extension ops,
// valid/ready on both sides with no overlap between requests.
//
//   state | meaning
//   IDLE  | ready for a request, in_ready high
//   CALC  | M op iterating in alu_mc_mul_div_iter
//   DONE  | result presented, waiting for out_ready
module alu_mc
   import alu_mc_pkg::*;
#(
   parameter int XLEN = 32
) (
   input logic    clk,
   input logic    reset_n,
   alu_mc_if.slave bus
);

   localparam int SW = $clog2(XLEN);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                 state_q;
   state_t                 state_d;
   logic                   accept;
   logic                   start;
   logic                   is_m;
   logic                   is_m_q;
   logic                   have_res_q;
   logic                   iter_done;
   logic [SW-1:0]          shamt;
   logic signed [XLEN-1:0] sra_res;
   logic [XLEN-1:0]        alu_res;
   logic [XLEN-1:0]        res_q;
   logic [XLEN-1:0]        iter_res;
   logic [XLEN-1:0]        res;

   assign is_m    = (bus.fun7 == F7_MULDIV);
   assign shamt   = bus.rs2[SW-1:0];
   // Kept as its own signed assignment so the shift stays arithmetic.
   assign sra_res = $signed(bus.rs1) >>> shamt;

   always_comb begin
      alu_res = '0;
      case (bus.fun3)
         ALU_ADD:  alu_res = bus.fun7[5] ? (bus.rs1 - bus.rs2) : (bus.rs1 + bus.rs2);
         ALU_SLL:  alu_res = bus.rs1 << shamt;
         ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(bus.rs1) < $signed(bus.rs2))};
         ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (bus.rs1 < bus.rs2)};
         ALU_XOR:  alu_res = bus.rs1 ^ bus.rs2;
         ALU_SRL:  alu_res = bus.fun7[5] ? sra_res : (bus.rs1 >> shamt);
         ALU_OR:   alu_res = bus.rs1 | bus.rs2;
         ALU_AND:  alu_res = bus.rs1 & bus.rs2;
         default:  alu_res = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      start   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               accept  = 1'b1;
               start   = is_m;
               state_d = is_m ? CALC : DONE;
            end
         end
         CALC: begin
            if (iter_done) state_d = DONE;
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         is_m_q     <= 1'b0;
         res_q      <= '0;
         have_res_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            is_m_q <= is_m;
            if (!is_m) res_q <= alu_res;
         end
         if (state_d == DONE) have_res_q <= 1'b1;
      end
   end

   alu_mc_mul_div_iter #(.XLEN(XLEN)) u_iter (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .op      (bus.fun3),
      .a       (bus.rs1),
      .b       (bus.rs2),
      .done    (iter_done),
      .result  (iter_res)
   );

   // Iterator registers freeze once finished, so the mux output is stable through DONE.
   assign res           = is_m_q ? iter_res : res_q;
   assign bus.res       = res;
   assign bus.zero      = have_res_q && (res == '0);
   assign bus.neg       = res[XLEN-1];
   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);

endmodule

// File: tb/tb_alu_mc.sv
// Directed and model-checked bench for alu_mc at XLEN=32 and XLEN=16.
module tb_alu_mc;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst32_n;
   logic rst16_n;
   int   tests = 0;
   int   fails = 0;

   alu_mc_if #(.XLEN(32)) b32 ();
   alu_mc_if #(.XLEN(16)) b16 ();

   alu_mc #(.XLEN(32)) dut32 (.clk(clk), .reset_n(rst32_n), .bus(b32));
   alu_mc #(.XLEN(16)) dut16 (.clk(clk), .reset_n(rst16_n), .bus(b16));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic op32(input string tag, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int elat);
      int lat;
      b32.fun7 = f7; b32.fun3 = f3; b32.rs1 = a; b32.rs2 = b; b32.in_valid = 1'b1;
      chk({tag, ".in_ready"}, 64'(b32.in_ready), 64'(1));
      @(posedge clk); #1;
      b32.in_valid = 1'b0; b32.rs1 = ~a; b32.rs2 = a ^ b; b32.fun3 = ~f3;
      lat = 0;
      while (b32.out_valid !== 1'b1 && lat < 200) begin
         @(posedge clk); #1; lat++;
      end
      chk({tag, ".lat"}, 64'(lat), 64'(elat));
      chk({tag, ".res"}, 64'(b32.res), 64'(exp));
      chk({tag, ".zn"}, 64'({b32.zero, b32.neg}), 64'({exp == 32'd0, exp[31]}));
      b32.out_ready = 1'b1;
      @(posedge clk); #1;
      b32.out_ready = 1'b0;
   endtask

   task automatic op16(input string tag, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] exp, input int elat);
      int lat;
      b16.fun7 = f7; b16.fun3 = f3; b16.rs1 = a; b16.rs2 = b; b16.in_valid = 1'b1;
      @(posedge clk); #1;
      b16.in_valid = 1'b0; b16.rs1 = ~a; b16.rs2 = ~b;
      lat = 0;
      while (b16.out_valid !== 1'b1 && lat < 200) begin
         @(posedge clk); #1; lat++;
      end
      chk({tag, ".lat"}, 64'(lat), 64'(elat));
      chk({tag, ".res"}, 64'(b16.res), 64'(exp));
      chk({tag, ".zn"}, 64'({b16.zero, b16.neg}), 64'({exp == 16'd0, exp[15]}));
      b16.out_ready = 1'b1;
      @(posedge clk); #1;
      b16.out_ready = 1'b0;
   endtask

   function automatic logic [15:0] ref16(input logic [6:0] f7, input logic [2:0] f3,
                                         input logic [15:0] a, input logic [15:0] b);
      longint sa, sb, ua, ub, p;
      logic [3:0] sh;
      sa = longint'($signed(a)); sb = longint'($signed(b));
      ua = longint'(a);          ub = longint'(b);
      sh = b[3:0];
      if (f7 == 7'h01) begin
         case (f3)
            3'd0: begin p = sa * sb; return p[15:0]; end
            3'd1: begin p = sa * sb; return p[31:16]; end
            3'd2: begin p = sa * ub; return p[31:16]; end
            3'd3: begin p = ua * ub; return p[31:16]; end
            3'd4: begin
               if (b == 16'd0) return 16'hFFFF;
               if (a == 16'h8000 && b == 16'hFFFF) return a;
               p = sa / sb; return p[15:0];
            end
            3'd5: begin
               if (b == 16'd0) return 16'hFFFF;
               p = ua / ub; return p[15:0];
            end
            3'd6: begin
               if (b == 16'd0) return a;
               if (a == 16'h8000 && b == 16'hFFFF) return 16'd0;
               p = sa % sb; return p[15:0];
            end
            default: begin
               if (b == 16'd0) return a;
               p = ua % ub; return p[15:0];
            end
         endcase
      end
      case (f3)
         3'd0: return f7[5] ? 16'(a - b) : 16'(a + b);
         3'd1: return 16'(a << sh);
         3'd2: return (sa < sb) ? 16'd1 : 16'd0;
         3'd3: return (ua < ub) ? 16'd1 : 16'd0;
         3'd4: return a ^ b;
         3'd5: begin
            if (!f7[5]) return 16'(a >> sh);
            p = sa >>> sh; return p[15:0];
         end
         3'd6: return a | b;
         default: return a & b;
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        stable;
      logic        seen;
      logic [6:0]  f7;
      logic [2:0]  f3;
      logic [15:0] a16;
      logic [15:0] b16v;

      rst32_n = 1'b0; rst16_n = 1'b0;
      b32.in_valid = 1'b0; b32.out_ready = 1'b0; b32.fun7 = '0; b32.fun3 = '0; b32.rs1 = '0; b32.rs2 = '0;
      b16.in_valid = 1'b0; b16.out_ready = 1'b0; b16.fun7 = '0; b16.fun3 = '0; b16.rs1 = '0; b16.rs2 = '0;
      repeat (3) @(posedge clk);
      #1;
      rst32_n = 1'b1; rst16_n = 1'b1;
      chk("rst.out_valid", 64'(b32.out_valid), 64'(0));
      chk("rst.in_ready", 64'(b32.in_ready), 64'(1));
      chk("rst.res", 64'(b32.res), 64'(0));
      chk("rst.zn", 64'({b32.zero, b32.neg}), 64'(0));

      // base ops: out_valid right after the accept edge
      op32("sub",  7'h20, 3'd0, 32'd5,          32'd7,          32'hFFFF_FFFE, 0);
      op32("sra",  7'h20, 3'd5, 32'h8000_0000,  32'h21,         32'hC000_0000, 0);
      op32("srl",  7'h00, 3'd5, 32'h8000_0000,  32'h4,          32'h0800_0000, 0);
      op32("add",  7'h00, 3'd0, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000, 0);
      op32("sll",  7'h00, 3'd1, 32'd1,          32'h3F,         32'h8000_0000, 0);
      op32("slt",  7'h00, 3'd2, 32'hFFFF_FFFF,  32'd1,          32'd1,         0);
      op32("sltu", 7'h00, 3'd3, 32'hFFFF_FFFF,  32'd1,          32'd0,         0);
      op32("xor",  7'h00, 3'd4, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'h0FF0_0FF0, 0);
      op32("or",   7'h00, 3'd6, 32'hF0F0_0000,  32'h0000_000F,  32'hF0F0_000F, 0);
      op32("and",  7'h00, 3'd7, 32'hF0F0_F0F0,  32'h0F0F_0F0F,  32'd0,         0);

      // M ops: out_valid XLEN edges after the accept edge
      op32("mulh",   7'h01, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32);
      op32("mulhu",  7'h01, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32);
      op32("mulhsu", 7'h01, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32);
      op32("mul0",   7'h01, 3'd0, 32'h0001_0000, 32'h0001_0000, 32'd0,         32);
      op32("mulneg", 7'h01, 3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 32);
      op32("div",    7'h01, 3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32);
      op32("rem",    7'h01, 3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32);
      op32("divu0",  7'h01, 3'd5, 32'd7,         32'd0,         32'hFFFF_FFFF, 32);
      op32("remu0",  7'h01, 3'd7, 32'd7,         32'd0,         32'd7,         32);
      op32("divs0",  7'h01, 3'd4, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 32);
      op32("rems0",  7'h01, 3'd6, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32);
      op32("divovf", 7'h01, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32);
      op32("removf", 7'h01, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32);
      op32("divu",   7'h01, 3'd5, 32'd100,       32'd7,         32'd14,        32);
      op32("remu",   7'h01, 3'd7, 32'd100,       32'd7,         32'd2,         32);

      // reset in the middle of a divide
      b32.fun7 = 7'h01; b32.fun3 = 3'd4; b32.rs1 = 32'd1000; b32.rs2 = 32'd3; b32.in_valid = 1'b1;
      @(posedge clk); #1;
      b32.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst32_n = 1'b0;
      #1;
      chk("rstdiv.out_valid", 64'(b32.out_valid), 64'(0));
      chk("rstdiv.in_ready", 64'(b32.in_ready), 64'(1));
      @(posedge clk); #1;
      rst32_n = 1'b1;
      chk("rstdiv.res", 64'(b32.res), 64'(0));
      chk("rstdiv.zn", 64'({b32.zero, b32.neg}), 64'(0));
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (b32.out_valid !== 1'b0) seen = 1'b1;
      end
      chk("rstdiv.no_result", 64'(seen), 64'(0));

      // back-pressure: result held, new requests ignored until handshake
      b32.fun7 = 7'h00; b32.fun3 = 3'd0; b32.rs1 = 32'd3; b32.rs2 = 32'd4; b32.in_valid = 1'b1;
      @(posedge clk); #1;
      b32.in_valid = 1'b0;
      chk("bp.out_valid", 64'(b32.out_valid), 64'(1));
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         b32.in_valid = i[0];
         b32.rs1 = $urandom;
         @(posedge clk); #1;
         if (b32.res !== 32'd7 || b32.zero !== 1'b0 || b32.neg !== 1'b0 ||
             b32.in_ready !== 1'b0 || b32.out_valid !== 1'b1) stable = 1'b0;
      end
      chk("bp.stable", 64'(stable), 64'(1));
      b32.fun3 = 3'd4; b32.rs1 = 32'hFF; b32.rs2 = 32'h0F; b32.in_valid = 1'b1; b32.out_ready = 1'b1;
      @(posedge clk); #1;
      b32.out_ready = 1'b0;
      chk("bp.after_hs_idle", 64'({b32.in_ready, b32.out_valid}), 64'(2'b10));
      @(posedge clk); #1;
      b32.in_valid = 1'b0;
      chk("bp.next_valid", 64'(b32.out_valid), 64'(1));
      chk("bp.next_res", 64'(b32.res), 64'(32'hF0));
      b32.out_ready = 1'b1;
      @(posedge clk); #1;
      b32.out_ready = 1'b0;

      // XLEN=16 instance
      op16("w16.divu",  7'h01, 3'd5, 16'hFFFF, 16'd3,    16'h5555, 16);
      op16("w16.mulhu", 7'h01, 3'd3, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16);
      op16("w16.divov", 7'h01, 3'd4, 16'h8000, 16'hFFFF, 16'h8000, 16);
      op16("w16.sra",   7'h20, 3'd5, 16'h8000, 16'h0013, 16'hF000, 0);
      for (int i = 0; i < 24; i++) begin
         f3 = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 2))
            0:       f7 = 7'h00;
            1:       f7 = 7'h20;
            default: f7 = 7'h01;
         endcase
         a16  = 16'($urandom);
         b16v = 16'($urandom);
         if (i % 6 == 0) b16v = 16'd0;
         if (i % 8 == 3) begin a16 = 16'h8000; b16v = 16'hFFFF; end
         op16($sformatf("w16.rnd%0d", i), f7, f3, a16, b16v,
              ref16(f7, f3, a16, b16v), (f7 == 7'h01) ? 16 : 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
